avl_mem_arbiter_2to1: RTL and testbench

- Two-master to one-slave Avalon-MM arbiter placed directly downstream of the cpu memory ports.
- avl_m_mem_bus_0 (I-side) and avl_m_mem_bus_1 (D-side) are merged onto the single SDRAM/on-chip memory controller port.
- Round-robin arbitration with grant held across pipelined reads, so read data always returns to the master that issued the read.
- Bounded hold time for fairness.

---
 rtl/avl_mem_arbiter_2to1.sv | 151 +++++++++++++++
 tb/tb_avl_mem_arbiter_2to1.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_mem_arbiter_2to1.sv
// Two-master to one-slave Avalon-MM arbiter. Round-robin grant, held while the owner
// keeps requesting (bounded by MAX_HOLD) and until its pipelined reads have returned.
module avl_mem_arbiter_2to1 #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAX_HOLD        = 16
) (
    input  logic                              clk,
    input  logic                              rest,
    input  logic [ADDR_W-1:0]                 s0_address,
    input  logic [DATA_W/8-1:0]               s0_byteenable,
    input  logic                              s0_read,
    input  logic                              s0_write,
    input  logic [DATA_W-1:0]                 s0_writedata,
    output logic [DATA_W-1:0]                 s0_readdata,
    output logic                              s0_readdatavalid,
    output logic                              s0_waitrequest,
    input  logic [ADDR_W-1:0]                 s1_address,
    input  logic [DATA_W/8-1:0]               s1_byteenable,
    input  logic                              s1_read,
    input  logic                              s1_write,
    input  logic [DATA_W-1:0]                 s1_writedata,
    output logic [DATA_W-1:0]                 s1_readdata,
    output logic                              s1_readdatavalid,
    output logic                              s1_waitrequest,
    output logic [ADDR_W-1:0]                 m_address,
    output logic [DATA_W/8-1:0]               m_byteenable,
    output logic                              m_read,
    output logic                              m_write,
    output logic [DATA_W-1:0]                 m_writedata,
    input  logic [DATA_W-1:0]                 m_readdata,
    input  logic                              m_readdatavalid,
    input  logic                              m_waitrequest,
    output logic [1:0]                        dbg_state,
    output logic                              dbg_owner,
    output logic [$clog2(MAX_OUTSTANDING):0]  dbg_outstanding
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [CNT_W-1:0]  OUT_FULL = CNT_W'(MAX_OUTSTANDING);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    // Handshake: a transfer is accepted on a rising edge where m_read or m_write is high and
    // m_waitrequest is low; the owner sees exactly that as its own read/write with waitrequest low.

    logic [1:0]        state;
    logic              owner;
    logic              last_grant;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstanding_nxt;
    logic [HOLD_W-1:0] hold_cnt;

    logic s0_req, s1_req;
    logic own_read, own_write, own_req, other_req;
    logic busy, stall, force_rel, own_wait;
    logic acc, acc_read, rdv_ok, release_own, winner;

    assign s0_req = s0_read | s0_write;
    assign s1_req = s1_read | s1_write;

    // Read+write together is treated as a read.
    assign own_read  = owner ? s1_read : s0_read;
    assign own_write = owner ? (s1_write & ~s1_read) : (s0_write & ~s0_read);
    assign own_req   = own_read | own_write;
    assign other_req = owner ? s0_req : s1_req;

    assign busy   = (state == BUSY);
    assign rdv_ok = m_readdatavalid & (outstanding != '0);

    // A slot freed by a return this cycle can be reused by a read in the same cycle.
    assign stall     = (outstanding == OUT_FULL) & ~rdv_ok;
    assign force_rel = other_req & (hold_cnt == HOLD_MAX);

    assign m_address    = owner ? s1_address    : s0_address;
    assign m_byteenable = owner ? s1_byteenable : s0_byteenable;
    assign m_writedata  = owner ? s1_writedata  : s0_writedata;
    assign m_read       = busy & own_read & ~stall & ~force_rel;
    assign m_write      = busy & own_write & ~force_rel;

    // Writes are posted and never wait on read slots.
    assign own_wait       = m_waitrequest | (own_read & stall) | force_rel;
    assign s0_waitrequest = ~(busy & ~owner) | own_wait;
    assign s1_waitrequest = ~(busy & owner) | own_wait;

    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;
    assign s0_readdatavalid = rdv_ok & (state != IDLE) & ~owner;
    assign s1_readdatavalid = rdv_ok & (state != IDLE) & owner;

    assign acc         = (m_read | m_write) & ~m_waitrequest;
    assign acc_read    = m_read & ~m_waitrequest;
    assign release_own = ~own_req | force_rel;
    assign winner      = (s0_req & s1_req) ? ~last_grant : s1_req;

    always_comb begin
        outstanding_nxt = outstanding;
        if (acc_read && !rdv_ok) begin
            outstanding_nxt = outstanding + CNT_W'(1);
        end else if (!acc_read && rdv_ok) begin
            outstanding_nxt = outstanding - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            outstanding <= '0;
            hold_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            case (state)
                IDLE: begin
                    if (s0_req || s1_req) begin
                        owner      <= winner;
                        last_grant <= winner;
                        hold_cnt   <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (acc && (hold_cnt != HOLD_MAX)) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                    if (release_own) begin
                        state <= (outstanding_nxt == '0) ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding_nxt == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state       = state;
    assign dbg_owner       = owner;
    assign dbg_outstanding = outstanding;

endmodule

// File: tb/tb_avl_mem_arbiter_2to1.sv
// Directed bench for avl_mem_arbiter_2to1: one task per scenario, cycle-exact expectations.
module tb_avl_mem_arbiter_2to1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic        clk;
    logic        rest;
    logic [31:0] s0_address, s1_address;
    logic [3:0]  s0_byteenable, s1_byteenable;
    logic        s0_read, s0_write, s1_read, s1_write;
    logic [31:0] s0_writedata, s1_writedata;
    logic [31:0] s0_readdata, s1_readdata;
    logic        s0_readdatavalid, s1_readdatavalid;
    logic        s0_waitrequest, s1_waitrequest;
    logic [31:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_read, m_write;
    logic [31:0] m_writedata, m_readdata;
    logic        m_readdatavalid, m_waitrequest;
    logic [1:0]  dbg_state;
    logic        dbg_owner;
    logic [2:0]  dbg_outstanding;

    int n_tests = 0;
    int n_fail  = 0;

    avl_mem_arbiter_2to1 #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .MAX_HOLD(16)
    ) dut (
        .clk(clk), .rest(rest),
        .s0_address(s0_address), .s0_byteenable(s0_byteenable), .s0_read(s0_read),
        .s0_write(s0_write), .s0_writedata(s0_writedata), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid), .s0_waitrequest(s0_waitrequest),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
        .m_address(m_address), .m_byteenable(m_byteenable), .m_read(m_read),
        .m_write(m_write), .m_writedata(m_writedata), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .m_waitrequest(m_waitrequest),
        .dbg_state(dbg_state), .dbg_owner(dbg_owner), .dbg_outstanding(dbg_outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        s0_address = '0; s0_byteenable = 4'hF; s0_read = 0; s0_write = 0; s0_writedata = '0;
        s1_address = '0; s1_byteenable = 4'hF; s1_read = 0; s1_write = 0; s1_writedata = '0;
        m_readdata = '0; m_readdatavalid = 0; m_waitrequest = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rest = 1;
        next_cycle();
        rest = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rest = 1;
        s0_read = 1; s1_write = 1; m_readdatavalid = 1;
        next_cycle();
        next_cycle();
        mid();
        n_tests++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL rst_m_read: got %b want 0", m_read); end
        n_tests++; if (m_write !== 1'b0) begin n_fail++; $display("FAIL rst_m_write: got %b want 0", m_write); end
        n_tests++; if (s0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_s0_wait: got %b want 1", s0_waitrequest); end
        n_tests++; if (s1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_s1_wait: got %b want 1", s1_waitrequest); end
        n_tests++; if ({s0_readdatavalid, s1_readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rdv: got %b want 00", {s0_readdatavalid, s1_readdatavalid}); end
        n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); end
        n_tests++; if (dbg_outstanding !== 3'd0) begin n_fail++; $display("FAIL rst_outstanding: got %0d want 0", dbg_outstanding); end
        clear_inputs();
        rest = 0;
        next_cycle();
    endtask

    task automatic test_single_read;
        do_reset();
        s0_read = 1; s0_address = 32'h100; s0_byteenable = 4'hF;
        mid();
        n_tests++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL rd_idle_mread: got %b want 0", m_read); end
        n_tests++; if (s0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rd_idle_wait: got %b want 1", s0_waitrequest); end
        next_cycle();
        mid();
        n_tests++; if (m_read !== 1'b1) begin n_fail++; $display("FAIL rd_fwd_mread: got %b want 1", m_read); end
        n_tests++; if (m_address !== 32'h100) begin n_fail++; $display("FAIL rd_fwd_addr: got %h want 00000100", m_address); end
        n_tests++; if (m_byteenable !== 4'hF) begin n_fail++; $display("FAIL rd_fwd_be: got %h want f", m_byteenable); end
        n_tests++; if (s0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rd_fwd_wait: got %b want 0", s0_waitrequest); end
        next_cycle();
        s0_read = 0;
        mid();
        n_tests++; if (dbg_outstanding !== 3'd1) begin n_fail++; $display("FAIL rd_outstanding1: got %0d want 1", dbg_outstanding); end
        n_tests++; if (s0_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rd_early_rdv1: got %b want 0", s0_readdatavalid); end
        next_cycle();
        mid();
        n_tests++; if (dbg_state !== DRAIN) begin n_fail++; $display("FAIL rd_drain_state: got %0d want %0d", dbg_state, DRAIN); end
        n_tests++; if (s0_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rd_early_rdv2: got %b want 0", s0_readdatavalid); end
        next_cycle();
        m_readdatavalid = 1; m_readdata = 32'hDEADBEEF;
        mid();
        n_tests++; if (s0_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL rd_ret_rdv: got %b want 1", s0_readdatavalid); end
        n_tests++; if (s0_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_ret_data: got %h want deadbeef", s0_readdata); end
        n_tests++; if (s1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rd_ret_s1rdv: got %b want 0", s1_readdatavalid); end
        next_cycle();
        m_readdatavalid = 0;
        mid();
        n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rd_end_state: got %0d want %0d", dbg_state, IDLE); end
        n_tests++; if (dbg_outstanding !== 3'd0) begin n_fail++; $display("FAIL rd_end_outstanding: got %0d want 0", dbg_outstanding); end
    endtask

    task automatic test_round_robin;
        do_reset();
        s0_write = 1; s0_address = 32'h200; s0_writedata = 32'h11111111;
        s1_write = 1; s1_address = 32'h300; s1_writedata = 32'h22222222;
        next_cycle();
        mid();
        n_tests++; if (dbg_owner !== 1'b0) begin n_fail++; $display("FAIL rr_first_owner: got %b want 0", dbg_owner); end
        n_tests++; if (m_write !== 1'b1 || m_address !== 32'h200) begin n_fail++; $display("FAIL rr_first_fwd: got wr=%b addr=%h want wr=1 addr=00000200", m_write, m_address); end
        n_tests++; if (m_writedata !== 32'h11111111) begin n_fail++; $display("FAIL rr_first_data: got %h want 11111111", m_writedata); end
        n_tests++; if ({s0_waitrequest, s1_waitrequest} !== 2'b01) begin n_fail++; $display("FAIL rr_first_wait: got %b want 01", {s0_waitrequest, s1_waitrequest}); end
        next_cycle();
        s0_write = 0;
        mid();
        n_tests++; if (s1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rr_release_wait: got %b want 1", s1_waitrequest); end
        next_cycle();
        s0_write = 1;
        mid();
        n_tests++; if (dbg_state !== IDLE || {s0_waitrequest, s1_waitrequest} !== 2'b11) begin n_fail++; $display("FAIL rr_idle: got state=%0d wait=%b want state=0 wait=11", dbg_state, {s0_waitrequest, s1_waitrequest}); end
        next_cycle();
        mid();
        n_tests++; if (dbg_owner !== 1'b1) begin n_fail++; $display("FAIL rr_second_owner: got %b want 1", dbg_owner); end
        n_tests++; if (m_address !== 32'h300 || m_writedata !== 32'h22222222) begin n_fail++; $display("FAIL rr_second_fwd: got addr=%h data=%h want 00000300/22222222", m_address, m_writedata); end
        n_tests++; if ({s0_waitrequest, s1_waitrequest} !== 2'b10) begin n_fail++; $display("FAIL rr_second_wait: got %b want 10", {s0_waitrequest, s1_waitrequest}); end
        next_cycle();
        s0_write = 0; s1_write = 0;
        next_cycle();
        mid();
        n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rr_end_state: got %0d want %0d", dbg_state, IDLE); end
    endtask

    task automatic test_max_outstanding;
        do_reset();
        s1_read = 1; s1_address = 32'h1000;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            mid();
            n_tests++; if (m_read !== 1'b1 || s1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL mo_accept%0d: got rd=%b wait=%b want rd=1 wait=0", i, m_read, s1_waitrequest); end
            n_tests++; if (m_address !== 32'h1000 + 32'(4 * i)) begin n_fail++; $display("FAIL mo_addr%0d: got %h want %h", i, m_address, 32'h1000 + 32'(4 * i)); end
            next_cycle();
            s1_address = s1_address + 32'd4;
        end
        mid();
        n_tests++; if (dbg_outstanding !== 3'd4) begin n_fail++; $display("FAIL mo_full_cnt: got %0d want 4", dbg_outstanding); end
        n_tests++; if (s1_waitrequest !== 1'b1 || m_read !== 1'b0) begin n_fail++; $display("FAIL mo_5th_stall: got wait=%b rd=%b want wait=1 rd=0", s1_waitrequest, m_read); end
        next_cycle();
        m_readdatavalid = 1; m_readdata = 32'hA0A00000;
        mid();
        n_tests++; if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'hA0A00000) begin n_fail++; $display("FAIL mo_ret1: got rdv=%b data=%h want 1/a0a00000", s1_readdatavalid, s1_readdata); end
        n_tests++; if (m_read !== 1'b1 || s1_waitrequest !== 1'b0 || m_address !== 32'h1010) begin n_fail++; $display("FAIL mo_5th_same_cycle: got rd=%b wait=%b addr=%h want 1/0/00001010", m_read, s1_waitrequest, m_address); end
        next_cycle();
        m_readdatavalid = 0; s1_address = 32'h1014;
        mid();
        n_tests++; if (dbg_outstanding !== 3'd4) begin n_fail++; $display("FAIL mo_cnt_after5: got %0d want 4", dbg_outstanding); end
        n_tests++; if (s1_waitrequest !== 1'b1 || m_read !== 1'b0) begin n_fail++; $display("FAIL mo_6th_stall: got wait=%b rd=%b want 1/0", s1_waitrequest, m_read); end
        next_cycle();
        m_readdatavalid = 1; m_readdata = 32'hA0A00001;
        mid();
        n_tests++; if (m_read !== 1'b1 || m_address !== 32'h1014) begin n_fail++; $display("FAIL mo_6th_accept: got rd=%b addr=%h want 1/00001014", m_read, m_address); end
        next_cycle();
        s1_read = 0; m_readdatavalid = 0;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            m_readdatavalid = 1; m_readdata = 32'hB0B00000 + 32'(i);
            mid();
            n_tests++; if (dbg_state !== DRAIN || s1_readdatavalid !== 1'b1 || s0_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL mo_drain%0d: got state=%0d rdv1=%b rdv0=%b want 2/1/0", i, dbg_state, s1_readdatavalid, s0_readdatavalid); end
            next_cycle();
        end
        m_readdatavalid = 0;
        mid();
        n_tests++; if (dbg_state !== IDLE || dbg_outstanding !== 3'd0) begin n_fail++; $display("FAIL mo_end: got state=%0d cnt=%0d want 0/0", dbg_state, dbg_outstanding); end
    endtask

    task automatic test_max_hold;
        int wr_acc = 0;
        int s1_acc_at = -1;
        int rdv_at = -1;
        bit seen_idle = 0;
        bit masked_chk = 0;
        bit s1_data_seen = 0;
        bit s0_rdv_seen = 0;
        do_reset();
        s1_read = 1; s1_address = 32'h5000;
        for (int c = 0; c < 100 && !(wr_acc == 20 && s1_data_seen && dbg_state == IDLE); c++) begin
            m_readdatavalid = (c == rdv_at);
            m_readdata = 32'h5A5A5A5A;
            s0_write = (wr_acc < 20);
            s0_address = 32'h4000 + 32'(4 * wr_acc);
            s0_writedata = 32'(wr_acc);
            mid();
            if (s0_readdatavalid) s0_rdv_seen = 1;
            if (s1_readdatavalid && s1_readdata === 32'h5A5A5A5A) s1_data_seen = 1;
            if (dbg_state == IDLE && wr_acc == 16 && s1_acc_at < 0) seen_idle = 1;
            if (!masked_chk && dbg_state == BUSY && dbg_owner == 1'b0 && wr_acc == 16) begin
                masked_chk = 1;
                n_tests++; if (m_write !== 1'b0 || s0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL mh_masked: got wr=%b wait=%b want 0/1", m_write, s0_waitrequest); end
            end
            if (m_write && !m_waitrequest) begin
                n_tests++; if (m_writedata !== 32'(wr_acc) || m_address !== 32'h4000 + 32'(4 * wr_acc)) begin n_fail++; $display("FAIL mh_wr%0d: got data=%h addr=%h want %h/%h", wr_acc, m_writedata, m_address, 32'(wr_acc), 32'h4000 + 32'(4 * wr_acc)); end
                wr_acc++;
            end
            if (s1_read && !s1_waitrequest) begin
                s1_acc_at = wr_acc;
                rdv_at = c + 2;
            end
            next_cycle();
            if (s1_acc_at >= 0) s1_read = 0;
        end
        clear_inputs();
        n_tests++; if (wr_acc !== 20) begin n_fail++; $display("FAIL mh_total_writes: got %0d want 20", wr_acc); end
        n_tests++; if (s1_acc_at !== 16) begin n_fail++; $display("FAIL mh_writes_before_s1: got %0d want 16", s1_acc_at); end
        n_tests++; if (seen_idle !== 1'b1) begin n_fail++; $display("FAIL mh_idle_between: got %b want 1", seen_idle); end
        n_tests++; if (masked_chk !== 1'b1) begin n_fail++; $display("FAIL mh_masked_seen: got %b want 1", masked_chk); end
        n_tests++; if (s1_data_seen !== 1'b1 || s0_rdv_seen !== 1'b0) begin n_fail++; $display("FAIL mh_s1_return: got s1=%b s0=%b want 1/0", s1_data_seen, s0_rdv_seen); end
    endtask

    task automatic test_drain;
        do_reset();
        s0_read = 1; s0_address = 32'h600;
        next_cycle();
        mid();
        n_tests++; if (m_read !== 1'b1) begin n_fail++; $display("FAIL dr_rd1: got %b want 1", m_read); end
        next_cycle();
        s0_address = 32'h604;
        mid();
        n_tests++; if (m_read !== 1'b1 || s0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL dr_rd2: got rd=%b wait=%b want 1/0", m_read, s0_waitrequest); end
        next_cycle();
        s0_read = 0; s1_read = 1; s1_address = 32'h700;
        mid();
        n_tests++; if (s1_waitrequest !== 1'b1 || dbg_outstanding !== 3'd2) begin n_fail++; $display("FAIL dr_release: got wait=%b cnt=%0d want 1/2", s1_waitrequest, dbg_outstanding); end
        next_cycle();
        mid();
        n_tests++; if (dbg_state !== DRAIN || s1_waitrequest !== 1'b1 || m_read !== 1'b0) begin n_fail++; $display("FAIL dr_in_drain: got state=%0d wait=%b rd=%b want 2/1/0", dbg_state, s1_waitrequest, m_read); end
        next_cycle();
        m_readdatavalid = 1; m_readdata = 32'h0D0D0001;
        mid();
        n_tests++; if (s0_readdatavalid !== 1'b1 || s1_readdatavalid !== 1'b0 || s0_readdata !== 32'h0D0D0001) begin n_fail++; $display("FAIL dr_ret1: got rdv0=%b rdv1=%b data=%h want 1/0/0d0d0001", s0_readdatavalid, s1_readdatavalid, s0_readdata); end
        next_cycle();
        m_readdatavalid = 0;
        mid();
        n_tests++; if (dbg_state !== DRAIN || dbg_outstanding !== 3'd1 || s1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL dr_mid: got state=%0d cnt=%0d wait=%b want 2/1/1", dbg_state, dbg_outstanding, s1_waitrequest); end
        next_cycle();
        m_readdatavalid = 1; m_readdata = 32'h0D0D0002;
        mid();
        n_tests++; if (s0_readdatavalid !== 1'b1 || s1_readdatavalid !== 1'b0 || s0_readdata !== 32'h0D0D0002) begin n_fail++; $display("FAIL dr_ret2: got rdv0=%b rdv1=%b data=%h want 1/0/0d0d0002", s0_readdatavalid, s1_readdatavalid, s0_readdata); end
        next_cycle();
        m_readdatavalid = 0;
        mid();
        n_tests++; if (dbg_state !== IDLE || s1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL dr_idle: got state=%0d wait=%b want 0/1", dbg_state, s1_waitrequest); end
        next_cycle();
        mid();
        n_tests++; if (dbg_owner !== 1'b1 || s1_waitrequest !== 1'b0 || m_address !== 32'h700) begin n_fail++; $display("FAIL dr_s1_grant: got owner=%b wait=%b addr=%h want 1/0/00000700", dbg_owner, s1_waitrequest, m_address); end
        next_cycle();
        s1_read = 0;
        next_cycle();
        m_readdatavalid = 1; m_readdata = 32'h0E0E0001;
        mid();
        n_tests++; if (s1_readdatavalid !== 1'b1 || s0_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL dr_s1_ret: got rdv1=%b rdv0=%b want 1/0", s1_readdatavalid, s0_readdatavalid); end
        next_cycle();
        m_readdatavalid = 0;
        mid();
        n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL dr_end: got state=%0d want 0", dbg_state); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        s0_read = 1; s0_address = 32'h800;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            s0_address = s0_address + 32'd4;
        end
        s0_read = 0; rest = 1;
        mid();
        n_tests++; if (dbg_outstanding !== 3'd3) begin n_fail++; $display("FAIL rm_before: got %0d want 3", dbg_outstanding); end
        next_cycle();
        rest = 0; m_readdatavalid = 1; m_readdata = 32'hBAD0BAD0;
        mid();
        n_tests++; if ({s0_readdatavalid, s1_readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL rm_stray_rdv: got %b want 00", {s0_readdatavalid, s1_readdatavalid}); end
        n_tests++; if (dbg_state !== IDLE || dbg_outstanding !== 3'd0) begin n_fail++; $display("FAIL rm_after_rst: got state=%0d cnt=%0d want 0/0", dbg_state, dbg_outstanding); end
        next_cycle();
        m_readdatavalid = 0;
        mid();
        n_tests++; if (dbg_state !== IDLE || dbg_outstanding !== 3'd0) begin n_fail++; $display("FAIL rm_after_stray: got state=%0d cnt=%0d want 0/0", dbg_state, dbg_outstanding); end
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rest = 1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_max_outstanding();
        test_max_hold();
        test_drain();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
